// File: rtl/xgmii_rx_engine.sv
// xgmii_rx_engine: receives XGMII frames and parses the Ethernet/IPv4/UDP headers.
// It checks the magic tag and the FCS, buffers the payload of an accepted frame,
// and commits that payload plus a trailer word to a 72-bit {ctrl, data} FIFO.
//
// FIFO handshake (wr_en/full): a word transfers in every cycle where wr_en is
// high. wr_en is never high while full is high. While the FIFO is full, din holds
// the pending word, and that word transfers in the first cycle full is low.

`ifndef MAGIC_CODE
`define MAGIC_CODE 32'h4d41_4743
`endif

module xgmii_rx_engine #(
  parameter logic [31:0] MAGIC_CODE        = `MAGIC_CODE,
  parameter logic [15:0] UDP_PORT          = 16'h0900,
  parameter int          MAX_PAYLOAD_WORDS = 8
) (
  input  logic        xgmii_clk,
  input  logic        sys_rst,
  input  logic [71:0] xgmii_rxd,
  input  logic [47:0] if_macaddr,
  input  logic [31:0] if_v4addr,
  output logic [71:0] din,
  output logic        wr_en,
  input  logic        full,
  output logic [31:0] rx_frame_count,
  output logic [31:0] rx_drop_count,
  output logic [2:0]  dbg_state
);

  localparam int AW = $clog2(MAX_PAYLOAD_WORDS);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAX_WORDS = CW'(MAX_PAYLOAD_WORDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHECK   = 3'd3,
    S_COMMIT  = 3'd4,
    S_DROP    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    rxc;
  logic [63:0]   rxd;
  logic [7:0]    ln [8];
  logic          is_start, is_ctrl, is_term, has_err, hdr_ok, check_pass;
  logic [2:0]    hdr_idx;
  logic [CW-1:0] wcount, rd_ptr;
  logic [31:0]   crc_q, crc_next, fcs_q, src_ip;
  logic [15:0]   byte_count;
  logic [71:0]   commit_word;
  logic [63:0]   pay_mem [MAX_PAYLOAD_WORDS];
  logic          frame_start, hdr_adv, pay_store, term_cap, rd_adv, frame_inc;
  logic [1:0]    drop_inc;

  // Reflected IEEE CRC-32 over one word: lane 0 goes first, and each byte goes LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [63:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 64; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hedb8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign rxc         = xgmii_rxd[71:64];
  assign rxd         = xgmii_rxd[63:0];
  assign is_start    = (rxc == 8'h01) && (rxd[7:0] == 8'hfb);
  assign is_ctrl     = |rxc;
  assign is_term     = (rxc == 8'hf0) && (rxd[63:32] == 32'h0707_07fd);
  assign crc_next    = crc_step(crc_q, rxd);
  assign check_pass  = (wcount != '0) && (~crc_q == fcs_q);
  assign byte_count  = 16'({wcount, 3'b000});
  assign commit_word = (rd_ptr == wcount) ? {8'h00, src_ip, 16'h0000, byte_count}
                                          : {8'hff, pay_mem[rd_ptr[AW-1:0]]};
  assign dbg_state   = state_q;

  // Split the data word into byte lanes; lane i is rxd[8i+7:8i].
  always_comb begin
    for (int i = 0; i < 8; i++) ln[i] = rxd[8*i +: 8];
  end

  // Flag an error code (8'hfe) on any lane that carries a control character.
  always_comb begin
    has_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rxc[i] && (ln[i] == 8'hfe)) has_err = 1'b1;
    end
  end

  // Check each header word against its field values; lower lanes hold the MSBs.
  always_comb begin
    hdr_ok = 1'b0;
    case (hdr_idx)
      3'd1: hdr_ok = ({ln[0], ln[1], ln[2], ln[3], ln[4], ln[5]} == if_macaddr) ||
                     ({ln[0], ln[1], ln[2], ln[3], ln[4], ln[5]} == 48'hffff_ffff_ffff);
      3'd2: hdr_ok = (ln[4] == 8'h08) && (ln[5] == 8'h00) && (ln[6] == 8'h45);
      3'd3: hdr_ok = (ln[7] == 8'h11);
      3'd4: hdr_ok = ({ln[6], ln[7]} == if_v4addr[31:16]);
      3'd5: hdr_ok = ({ln[0], ln[1]} == if_v4addr[15:0]) && ({ln[4], ln[5]} == UDP_PORT);
      3'd6: hdr_ok = ({ln[2], ln[3], ln[4], ln[5]} == MAGIC_CODE);
      default: hdr_ok = 1'b0;
    endcase
  end

  // Next-state logic, datapath strobes, and FIFO outputs.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    hdr_adv     = 1'b0;
    pay_store   = 1'b0;
    term_cap    = 1'b0;
    rd_adv      = 1'b0;
    frame_inc   = 1'b0;
    drop_inc    = 2'd0;
    wr_en       = 1'b0;
    din         = '0;
    case (state_q)
      S_IDLE: begin
        if (is_start) begin
          frame_start = 1'b1;
          state_d     = S_HDR;
        end
      end
      S_HDR: begin
        if (is_ctrl || !hdr_ok) begin
          state_d  = S_DROP;
          drop_inc = 2'd1;
        end else begin
          hdr_adv = 1'b1;
          if (hdr_idx == 3'd6) state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!is_ctrl && (wcount != MAX_WORDS)) begin
          pay_store = 1'b1;
        end else if (is_term && !has_err) begin
          term_cap = 1'b1;
          state_d  = S_CHECK;
        end else begin
          state_d  = S_DROP;
          drop_inc = 2'd1;
        end
      end
      S_CHECK: begin
        if (check_pass) begin
          state_d = S_COMMIT;
        end else begin
          state_d  = S_IDLE;
          drop_inc = 2'd1;
        end
        // A frame that starts while this one is still in flight cannot be received.
        if (is_start) drop_inc = drop_inc + 2'd1;
      end
      S_COMMIT: begin
        if (is_start) drop_inc = 2'd1;
        din   = commit_word;
        wr_en = !full;
        if (!full) begin
          if (rd_ptr == wcount) begin
            frame_inc = 1'b1;
            state_d   = S_IDLE;
          end else begin
            rd_adv = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (is_ctrl && !is_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Frame bookkeeping: header index, word count, CRC, captured fields, and counters.
  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      hdr_idx        <= 3'd0;
      wcount         <= '0;
      rd_ptr         <= '0;
      crc_q          <= 32'hffff_ffff;
      fcs_q          <= 32'h0;
      src_ip         <= 32'h0;
      rx_frame_count <= 32'h0;
      rx_drop_count  <= 32'h0;
    end else begin
      if (frame_start) begin
        hdr_idx <= 3'd1;
        wcount  <= '0;
        rd_ptr  <= '0;
        crc_q   <= 32'hffff_ffff;
      end
      if (hdr_adv) begin
        hdr_idx <= hdr_idx + 3'd1;
        crc_q   <= crc_next;
        if (hdr_idx == 3'd4) src_ip <= {ln[2], ln[3], ln[4], ln[5]};
      end
      if (pay_store) begin
        wcount <= wcount + CW'(1);
        crc_q  <= crc_next;
      end
      if (term_cap) fcs_q <= rxd[31:0];
      if (rd_adv) rd_ptr <= rd_ptr + CW'(1);
      rx_frame_count <= rx_frame_count + 32'(frame_inc);
      rx_drop_count  <= rx_drop_count + 32'(drop_inc);
    end
  end

  // Payload buffer. It has no reset because the word count alone decides which entries are valid.
  always_ff @(posedge xgmii_clk) begin
    if (pay_store) pay_mem[wcount[AW-1:0]] <= rxd;
  end

endmodule
